// File: rtl/serial_eight_bit_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_eight_bit_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_eight_bit_subtractor_fsub.sv
// One-bit full subtractor: d = a - b - bi, bo set when the bit position borrows.
module full_subtractor_1b (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~a & bi) | (b & bi);

endmodule

// File: rtl/serial_eight_bit_subtractor.sv
// Bit-serial subtractor: diff = x - y - bin, one bit per clock, LSB first.
module serial_eight_bit_subtractor
  import serial_eight_bit_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Handshake: start is accepted only while idle (busy=0, done=0); busy stays
  // high for the WIDTH bit cycles, then done pulses for one cycle with
  // diff/bout/ovf valid; those outputs hold until the next done pulse.
  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] xs, ys, acc;
  logic            borrow;
  logic            bit_d, bit_bo;
  logic            last_bit;

  assign last_bit = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  full_subtractor_1b u_bit (
    .a  (xs[0]),
    .b  (ys[0]),
    .bi (borrow),
    .d  (bit_d),
    .bo (bit_bo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      borrow <= 1'b0;
      xs     <= '0;
      ys     <= '0;
      acc    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            xs     <= x;
            ys     <= y;
            borrow <= bin;
            cnt    <= '0;
          end
        end
        SHIFT: begin
          xs     <= xs >> 1;
          ys     <= ys >> 1;
          acc    <= {bit_d, acc[WIDTH-1:1]};
          borrow <= bit_bo;
          if (!last_bit) begin
            cnt <= cnt + 1'b1;
          end else begin
            // On the MSB cycle xs[0]/ys[0] are the operand sign bits.
            diff <= {bit_d, acc[WIDTH-1:1]};
            bout <= bit_bo;
            ovf  <= (xs[0] ^ ys[0]) & (bit_d ^ xs[0]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_eight_bit_subtractor.sv
// Directed-table and random bench for the bit-serial subtractor.
module tb_serial_eight_bit_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, start, bin;
  logic [W-1:0] x, y;
  logic         busy, done, bout, ovf;
  logic [W-1:0] diff;

  int checks   = 0;
  int failures = 0;

  logic [W+1:0] exp_q[$];  // {ovf, bout, diff}
  logic [W-1:0] last_diff;
  logic         last_bout, last_ovf;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } vec_t;

  vec_t vecs[8];

  serial_eight_bit_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .x     (x),
    .y     (y),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] xi, input logic [W-1:0] yi, input logic bi,
                        input string tag);
    int           lat;
    bit           seen;
    logic [W+1:0] e;
    x = xi; y = yi; bin = bi; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " busy_after_capture"}, 32'(busy), 32'd1);
    lat  = 0;
    seen = 0;
    while (lat < W + 4 && !seen) begin
      check({tag, " held_during_shift"}, 32'({ovf, bout, diff}),
            32'({last_ovf, last_bout, last_diff}));
      x = W'($urandom); y = W'($urandom); bin = 1'($urandom_range(0, 1));
      tick();
      lat++;
      if (done) seen = 1;
    end
    check({tag, " latency"}, 32'(lat), 32'(W));
    e = '0;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard_empty: got none expected entry", tag);
    end else begin
      e = exp_q.pop_front();
    end
    check({tag, " result"}, 32'({ovf, bout, diff}), 32'(e));
    check({tag, " busy_in_done"}, 32'(busy), 32'd0);
    {last_ovf, last_bout, last_diff} = e;
    tick();
    check({tag, " done_single_pulse"}, 32'({done, busy}), 32'd0);
  endtask

  initial begin
    int           ndone;
    int           first_lat;
    logic [W-1:0] first_diff;
    logic         first_bout;
    logic [W-1:0] xr, yr;
    logic         br;
    logic [W:0]   full;
    logic         ov;

    vecs[0] = '{x: 8'd5,   y: 8'd2,   bin: 1'b1, d: 8'd2,   bo: 1'b0, ov: 1'b0};
    vecs[1] = '{x: 8'd2,   y: 8'd144, bin: 1'b1, d: 8'd113, bo: 1'b1, ov: 1'b0};
    vecs[2] = '{x: 8'd255, y: 8'd254, bin: 1'b1, d: 8'd0,   bo: 1'b0, ov: 1'b0};
    vecs[3] = '{x: 8'd127, y: 8'd255, bin: 1'b0, d: 8'd128, bo: 1'b1, ov: 1'b1};
    vecs[4] = '{x: 8'd0,   y: 8'd0,   bin: 1'b1, d: 8'd255, bo: 1'b1, ov: 1'b0};
    vecs[5] = '{x: 8'd128, y: 8'd1,   bin: 1'b0, d: 8'd127, bo: 1'b0, ov: 1'b1};
    vecs[6] = '{x: 8'd200, y: 8'd100, bin: 1'b0, d: 8'd100, bo: 1'b0, ov: 1'b1};
    vecs[7] = '{x: 8'd0,   y: 8'd255, bin: 1'b1, d: 8'd0,   bo: 1'b1, ov: 1'b0};

    // Clock/reset
    reset = 1'b1; start = 1'b0; x = '0; y = '0; bin = 1'b0;
    repeat (3) tick();
    check("reset_outputs", 32'({busy, done, bout, ovf, diff}), 32'd0);
    last_diff = '0; last_bout = 1'b0; last_ovf = 1'b0;
    reset = 1'b0;

    // Table vectors; the first start lands on the first edge after reset
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({vecs[i].ov, vecs[i].bo, vecs[i].d});
      run_op(vecs[i].x, vecs[i].y, vecs[i].bin, $sformatf("vec%0d", i));
    end

    // Second start during SHIFT must be dropped, not queued
    x = 8'd5; y = 8'd2; bin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    x = 8'd100; y = 8'd50; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0; first_lat = 0; first_diff = '0; first_bout = 1'b0;
    for (int c = 4; c < 19; c++) begin
      tick();
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          first_lat = c; first_diff = diff; first_bout = bout;
        end
      end
    end
    check("ignore_start done_count", 32'(ndone), 32'd1);
    check("ignore_start latency", 32'(first_lat), 32'd8);
    check("ignore_start diff", 32'({first_bout, first_diff}), 32'({1'b0, 8'd2}));
    last_diff = 8'd2; last_bout = 1'b0; last_ovf = 1'b0;

    // Reset 4 cycles into SHIFT aborts without a done pulse
    x = 8'd5; y = 8'd2; bin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort busy_done", 32'({busy, done}), 32'd0);
    check("abort diff", 32'({ovf, bout, diff}), 32'd0);
    ndone = 0;
    repeat (12) begin
      tick();
      if (done) ndone++;
    end
    check("abort no_done", 32'(ndone), 32'd0);
    last_diff = '0; last_bout = 1'b0; last_ovf = 1'b0;
    exp_q.push_back({1'b1, 1'b0, 8'd100});
    run_op(8'd200, 8'd100, 1'b0, "after_abort");

    // Random back-to-back operations against a (W+1)-bit arithmetic model
    for (int n = 0; n < 1000; n++) begin
      xr = W'($urandom); yr = W'($urandom); br = 1'($urandom_range(0, 1));
      full = {1'b0, xr} - {1'b0, yr} - (W+1)'(br);
      ov = (xr[W-1] != yr[W-1]) && (full[W-1] != xr[W-1]);
      exp_q.push_back({ov, full});
      run_op(xr, yr, br, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_eight_bit_subtractor.md
SERIAL_EIGHT_BIT_SUBTRACTOR -- requirements
Module: serial_eight_bit_subtractor

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits; the block SHALL be correct for WIDTH 8 and for any WIDTH >= 2.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 Port: x  input  WIDTH  minuend, unsigned; captured on an accepted start.
REQ-006 Port: y  input  WIDTH  subtrahend, unsigned; captured on an accepted start.
REQ-007 Port: bin  input  1  borrow-in; captured on an accepted start.
REQ-008 Port: busy  output  1  high while an operation is in progress (SHIFT state).
REQ-009 Port: done  output  1  one-cycle pulse marking diff, bout and ovf valid.
REQ-010 Port: diff  output  WIDTH  result x - y - bin, modulo 2^WIDTH.
REQ-011 Port: bout  output  1  borrow-out; 1 iff x < y + bin (unsigned compare).
REQ-012 Port: ovf  output  1  signed overflow; 1 iff x[MSB] != y[MSB] and diff[MSB] != x[MSB].

Function
REQ-013 FSM states SHALL be IDLE, SHIFT and DONE only.
REQ-014 IDLE: start=1 at edge k SHALL capture x, y and bin, clear the bit counter, and move to SHIFT; start=0 SHALL keep IDLE.
REQ-015 SHIFT: each edge SHALL process one bit, LSB first, through a one-bit full subtractor; the borrow SHALL be registered between bits.
REQ-016 Bit i SHALL be processed at edge k+1+i; the counter SHALL be $clog2(WIDTH) bits wide and SHALL NOT wrap within one operation.
REQ-017 At edge k+WIDTH, the final bit edge, state SHALL go to DONE; done SHALL be 1 for exactly that one cycle.
REQ-018 DONE SHALL return to IDLE on the next edge unconditionally.
REQ-019 Latency: done SHALL rise exactly WIDTH cycles after the start-capture edge.
REQ-020 busy SHALL be 1 from edge k to edge k+WIDTH, and 0 in IDLE and DONE.
REQ-021 start asserted in SHIFT or DONE SHALL be ignored; it SHALL NOT be queued.
REQ-022 Changes on x, y or bin after capture SHALL NOT affect the result in progress.
REQ-023 diff, bout and ovf SHALL hold their last results from DONE until the next DONE; they SHALL NOT be exposed as partial values during SHIFT.
REQ-024 bin=1 with x=y=0 SHALL give diff = all-ones and bout=1.

Reset
REQ-025 reset=1 at an edge SHALL force IDLE and set busy=0, done=0, diff=0, bout=0, ovf=0; the counter and borrow SHALL be cleared.
REQ-026 reset SHALL take priority over start and over any in-progress operation; an interrupted operation SHALL be discarded without producing a done pulse.
REQ-027 start SHALL be accepted at the first edge after reset deasserts.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding (2-bit enum: IDLE, SHIFT, DONE) and the default WIDTH constant.
REQ-029 The per-bit logic SHALL be one sub-module, full_subtractor_1b (inputs a, b, bi; outputs d, bo), instantiated once.
REQ-030 No combinational path SHALL exist from any input to any output.

Verification
REQ-031 Apply x=5, y=2, bin=1 -> done 8 cycles after capture with diff=2, bout=0, ovf=0.
REQ-032 Apply x=2, y=144, bin=1 -> diff=113, bout=1, ovf=0; then x=255, y=254, bin=1 -> diff=0, bout=0.
REQ-033 Apply x=127, y=255, bin=0 -> diff=128, bout=1, ovf=1; then x=0, y=0, bin=1 -> diff=255, bout=1, ovf=0.
REQ-034 Pulse start again 3 cycles after capture with new operands -> ignored; the first result is unchanged and only one done pulse occurs.
REQ-035 Assert reset 4 cycles into SHIFT -> the next cycle shows busy=0, done=0, diff=0; no done follows; a new start then completes normally.
REQ-036 Run 1000 random back-to-back operations -> each diff and bout matches {bout,diff} = x - y - bin computed at WIDTH+1 bits, and done latency is always 8.
